// File: rtl/rr_fanin_collector.sv
// Round-robin fan-in: merges N valid/ready sources into one registered output channel.
// Define RR_FANIN_SRCID_EN to add the registered out_src source-index output.
module rr_fanin_collector #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    input  logic                 out_ready,
`ifdef RR_FANIN_SRCID_EN
    output logic [$clog2(N)-1:0] out_src,
`endif
    output logic [15:0]          beat_cnt
);

    localparam int unsigned PtrW = $clog2(N);

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [15:0]     beat_cnt_q;

    logic            found;
    logic            can_accept;
    logic            grant;
    logic [N-1:0]    win_oh;
    logic [W-1:0]    win_data;
    logic [PtrW-1:0] win_idx;

    // Search from ptr upward, wrapping; first valid source wins.
    always_comb begin
        found    = 1'b0;
        win_oh   = '0;
        win_data = '0;
        win_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = (int'(ptr_q) + k) % N;
            if (!found && in_valid[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_data    = in_data[idx*W +: W];
                win_idx     = idx[PtrW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (win_idx == PtrW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    assign can_accept = !out_valid_q || out_ready;
    // Inputs are ignored while reset is asserted, so no grant is offered then.
    assign grant      = found && can_accept && rst_n;
    assign in_ready   = grant ? win_oh : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            beat_cnt_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_data;
                if (beat_cnt_q != 16'hFFFF) begin
                    beat_cnt_q <= beat_cnt_q + 16'd1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef RR_FANIN_SRCID_EN
    logic [PtrW-1:0] out_src_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_src_q <= '0;
        end else if (grant) begin
            out_src_q <= win_idx;
        end
    end

    assign out_src = out_src_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_rr_fanin_collector.sv
// Directed self-checking bench for rr_fanin_collector (N=4, W=8).
// Honours RR_FANIN_SRCID_EN to also check out_src.
module tb_rr_fanin_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [15:0] beat_cnt;
`ifdef RR_FANIN_SRCID_EN
    logic [1:0]  out_src;
`endif

    int total = 0;
    int bad   = 0;

    rr_fanin_collector #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef RR_FANIN_SRCID_EN
        .out_src   (out_src),
`endif
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (out_valid !== 1'b0) begin bad++;
                $display("FAIL reset_out_valid cyc=%0d got=%b want=0", c, out_valid); end
            total++; if (in_ready !== 4'b0000) begin bad++;
                $display("FAIL reset_in_ready cyc=%0d got=%b want=0000", c, in_ready); end
            total++; if (beat_cnt !== 16'd0) begin bad++;
                $display("FAIL reset_beat_cnt cyc=%0d got=%h want=0000", c, beat_cnt); end
        end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++;
            $display("FAIL reset_first_grant got=%b want=0001", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin bad++;
            $display("FAIL reset_first_beat got=%b/%h want=1/10", out_valid, out_data); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data;
        do_reset();
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_data = 8'h10 + 8'(k % 4);
            total++; if (out_valid !== 1'b1 || out_data !== exp_data) begin bad++;
                $display("FAIL rr_beat k=%0d got=%b/%h want=1/%h", k, out_valid, out_data,
                         exp_data); end
`ifdef RR_FANIN_SRCID_EN
            total++; if (out_src !== 2'(k % 4)) begin bad++;
                $display("FAIL rr_src k=%0d got=%0d want=%0d", k, out_src, k % 4); end
`endif
        end
        total++; if (beat_cnt !== 16'd8) begin bad++;
            $display("FAIL rr_beat_cnt got=%0d want=8", beat_cnt); end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        in_data   = {8'h33, 8'h32, 8'h31, 8'h30};
        out_ready = 1'b1;
        in_valid  = 4'b0100;    // source 2 moves ptr to 3
        step();
        in_valid = 4'b0110;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++;
            $display("FAIL wrap_first_grant got=%b want=0010", in_ready); end
        step();
        total++; if (out_data !== 8'h31) begin bad++;
            $display("FAIL wrap_first_data got=%h want=31", out_data); end
        in_valid = 4'b0100;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++;
            $display("FAIL wrap_second_grant got=%b want=0100", in_ready); end
        step();
        total++; if (out_data !== 8'h32) begin bad++;
            $display("FAIL wrap_second_data got=%h want=32", out_data); end
        in_valid = 4'b1111;
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++;
            $display("FAIL wrap_ptr3 got=%b want=1000", in_ready); end
        in_valid = 4'b0000;
        step();
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL wrap_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        in_data   = {8'h24, 8'h23, 8'h22, 8'h21};
        out_ready = 1'b0;
        in_valid  = 4'b0001;    // output empty, so accepted despite out_ready=0
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin bad++;
            $display("FAIL bp_load got=%b/%h want=1/21", out_valid, out_data); end
        in_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (in_ready !== 4'b0000) begin bad++;
                $display("FAIL bp_in_ready cyc=%0d got=%b want=0000", c, in_ready); end
            step();
            total++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin bad++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/21", c, out_valid, out_data); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++;
            $display("FAIL bp_release_grant got=%b want=0010", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin bad++;
            $display("FAIL bp_replace got=%b/%h want=1/22", out_valid, out_data); end
        in_valid = 4'b0000;
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h22) begin bad++;
            $display("FAIL bp_drain_hold got=%b/%h want=0/22", out_valid, out_data); end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid  = 4'b1111;
        in_data   = {8'h43, 8'h42, 8'h41, 8'h40};
        out_ready = 1'b1;
        repeat (65534) step();
        total++; if (beat_cnt !== 16'hFFFE) begin bad++;
            $display("FAIL sat_preload got=%h want=fffe", beat_cnt); end
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (beat_cnt !== 16'hFFFF) begin bad++;
                $display("FAIL sat_hold cyc=%0d got=%h want=ffff", c, beat_cnt); end
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_data   = {8'h00, 8'hAB, 8'h00, 8'h00};
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        step();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 8'hAB) begin bad++;
            $display("FAIL mid_setup got=%b/%h want=1/ab", out_valid, out_data); end
        rst_n    = 1'b0;
        in_valid = 4'b1111;
        step();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++;
            $display("FAIL mid_clear got=%b/%h want=0/00", out_valid, out_data); end
        total++; if (beat_cnt !== 16'd0) begin bad++;
            $display("FAIL mid_beat_cnt got=%h want=0000", beat_cnt); end
`ifdef RR_FANIN_SRCID_EN
        total++; if (out_src !== 2'd0) begin bad++;
            $display("FAIL mid_src got=%0d want=0", out_src); end
`endif
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++;
            $display("FAIL mid_ptr0 got=%b want=0001", in_ready); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_backpressure();
        test_saturation();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
